// File: rtl/nibble_pkg.sv
// nibble_pkg
//   Shared definitions for the nibble deserializer: default word width,
//   the deserializer FSM state type and the even-parity helper.
//   Optional feature macro used by the design: PARITY_CHECK_EN.
package nibble_pkg;

  localparam int DEF_WORD_W = 4;
  // Widest legal word; the parity helper takes data zero-extended to this.
  localparam int MAX_WORD_W = 8;

  typedef enum logic [0:0] {
    S_SHIFT = 1'b0,
    S_PAR   = 1'b1
  } deser_state_t;

  // Returns 1 when data plus the parity bit hold an even number of ones.
  function automatic logic even_parity(input logic [MAX_WORD_W-1:0] data,
                                       input logic pbit);
    return ~(^data ^ pbit);
  endfunction

endpackage

// File: rtl/nibble_shift_reg.sv
// nibble_shift_reg
//   Serial-in shift register that gathers one word of data bits.
//   MSB_FIRST=1 shifts toward the MSB so the first bit ends in q[WORD_W-1];
//   MSB_FIRST=0 shifts toward the LSB so the first bit ends in q[0].
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous reset, active low (clears q)
//   shift_en in   shift bit_in into the register this cycle
//   bit_in   in   serial data bit
//   clr      in   clear q (wins over shift_en)
//   q        out  WORD_W-bit register contents
module nibble_shift_reg
  import nibble_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              clr,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) q <= {q[WORD_W-2:0], bit_in};
      else           q <= {bit_in, q[WORD_W-1:1]};
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// nibble_deserializer
//   Gathers a serial bit stream into WORD_W-bit words and presents each word
//   on a registered valid/ready port. Back-pressure reaches the serial side
//   so no word is lost or overwritten. Optional macro PARITY_CHECK_EN adds an
//   even-parity bit after each word; bad frames are dropped and flagged.
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous reset, active low
//   ser_in      in   serial data bit
//   ser_valid   in   ser_in valid
//   ser_ready   out  serial bit accepted when ser_valid && ser_ready
//   word_out    out  assembled word, stable while word_valid=1
//   word_valid  out  word_out valid
//   word_ready  in   consumer takes the word when word_valid && word_ready
//   par_err     out  one-cycle parity failure pulse (0 without PARITY_CHECK_EN)
//   word_count  out  delivered words, wraps modulo 2^CNT_W
//
// Handshake: both ports transfer on a clock edge where valid && ready are
// high together. word_valid/word_out are registered and only change on a
// transfer or a new load; ser_ready is combinational from word_ready and
// drops only when the last bit of a frame is offered while the output
// register holds a word that is not draining this cycle.
module nibble_deserializer
  import nibble_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic              ser_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              par_err,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  deser_state_t      state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] frame_word;
  logic accept, drain, data_last, final_pending;
  logic shift_en, clr, frame_end, parity_ok, load;

  nibble_shift_reg #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .bit_in   (ser_in),
    .clr      (clr),
    .q        (shift_q)
  );

  assign data_last = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);

`ifdef PARITY_CHECK_EN
  assign final_pending = (state_q == S_PAR);
`else
  assign final_pending = data_last;
`endif

  assign ser_ready = !(final_pending && word_valid && !word_ready);
  assign accept    = ser_valid && ser_ready;
  assign drain     = word_valid && word_ready;

  always_comb begin
    shift_en   = 1'b0;
    frame_end  = 1'b0;
    frame_word = shift_q;
    parity_ok  = 1'b1;
`ifdef PARITY_CHECK_EN
    // All data bits land in the shift register; the parity bit closes the frame.
    shift_en  = accept && (state_q == S_SHIFT);
    frame_end = accept && (state_q == S_PAR);
    parity_ok = even_parity(MAX_WORD_W'(shift_q), ser_in);
`else
    // The last data bit bypasses the shift register straight into the output
    // load, so the word is visible one clock after that bit is accepted.
    shift_en  = accept && !data_last;
    frame_end = accept && data_last;
    if (MSB_FIRST) frame_word = {shift_q[WORD_W-2:0], ser_in};
    else           frame_word = {ser_in, shift_q[WORD_W-1:1]};
`endif
    clr  = frame_end;
    load = frame_end && parity_ok;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SHIFT: begin
`ifdef PARITY_CHECK_EN
        if (accept && data_last) state_d = S_PAR;
`endif
      end
      S_PAR:   if (accept) state_d = S_SHIFT;
      default: state_d = S_SHIFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_SHIFT;
      bit_cnt_q  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (state_q == S_SHIFT)) begin
        bit_cnt_q <= data_last ? '0 : bit_cnt_q + BC_W'(1);
      end
      // A load in the same cycle as a drain keeps word_valid high (no bubble).
      if (load) begin
        word_out   <= frame_word;
        word_valid <= 1'b1;
      end else if (drain) begin
        word_valid <= 1'b0;
      end
      if (drain) word_count <= word_count + CNT_W'(1);
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= frame_end && !parity_ok;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
